aemb2_dpsram: RTL and testbench

Parametrised true dual-port synchronous on-chip SRAM, the next generation of the single-port SRAM macro. It gives the AEMB2 core, caches and DMA two independent read/write ports on one clock. Each port has byte-lane write enables, a selectable read-during-write mode and an optional output pipeline register. A per-port acknowledge strobe marks valid read data.

---
 rtl/aemb2_dpsram.sv | 148 ++++++++++++++
 tb/tb_aemb2_dpsram.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/aemb2_dpsram.sv
// aemb2_dpsram: true dual-port synchronous SRAM, single clock.
//
// Ports (A and B are identical):
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset (clears outputs/pipeline, not the array)
//   x_adr_i [AW]     word address
//   x_dat_i [DW]     write data
//   x_sel_i [DW/8]   byte-lane write enables
//   x_wre_i          write enable, qualified by x_ena_i
//   x_ena_i          access enable; every enabled access returns data
//   x_dat_o [DW]     read data, holds while x_ack_o is low
//   x_ack_o          one-cycle strobe marking valid x_dat_o
//
// Latency is 1 cycle (OREG=0) or 2 cycles (OREG=1) after the sampling edge.
module aemb2_dpsram #(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int RDW  = 0,
  parameter int OREG = 0,
  parameter int XFWD = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   a_adr_i,
  input  logic [DW-1:0]   a_dat_i,
  input  logic [DW/8-1:0] a_sel_i,
  input  logic            a_wre_i,
  input  logic            a_ena_i,
  output logic [DW-1:0]   a_dat_o,
  output logic            a_ack_o,
  input  logic [AW-1:0]   b_adr_i,
  input  logic [DW-1:0]   b_dat_i,
  input  logic [DW/8-1:0] b_sel_i,
  input  logic            b_wre_i,
  input  logic            b_ena_i,
  output logic [DW-1:0]   b_dat_o,
  output logic            b_ack_o
);
  localparam int SW = DW / 8;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          a_act, a_wr, b_act, b_wr, same_adr;
  logic [DW-1:0] a_old, b_old, a_rd, b_rd;

  logic [DW-1:0] a_dat1_q, a_dat1_d, b_dat1_q, b_dat1_d;
  logic          a_ack1_q, a_ack1_d, b_ack1_q, b_ack1_d;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] base,
                                                input logic [DW-1:0] wdat,
                                                input logic [SW-1:0] sel);
    logic [DW-1:0] res;
    res = base;
    for (int n = 0; n < SW; n++) begin
      if (sel[n]) res[8*n +: 8] = wdat[8*n +: 8];
    end
    return res;
  endfunction

  always_comb begin
    a_act    = a_ena_i & ~rst_i;
    b_act    = b_ena_i & ~rst_i;
    a_wr     = a_act & a_wre_i;
    b_wr     = b_act & b_wre_i;
    same_adr = (a_adr_i == b_adr_i);
    a_old    = mem[a_adr_i];
    b_old    = mem[b_adr_i];
  end

  // Returned word: old data, optionally overlaid with the other port's lanes
  // (cross forwarding) and with this port's own lanes (write-first).
  // Port A is applied last on B's view so a forwarded lane matches what the
  // array actually holds after an A/B lane collision.
  always_comb begin
    a_rd = a_old;
    if (XFWD != 0 && b_wr && same_adr) a_rd = merge_lanes(a_rd, b_dat_i, b_sel_i);
    if (RDW == 0 && a_wr)              a_rd = merge_lanes(a_rd, a_dat_i, a_sel_i);
    b_rd = b_old;
    if (RDW == 0 && b_wr)              b_rd = merge_lanes(b_rd, b_dat_i, b_sel_i);
    if (XFWD != 0 && a_wr && same_adr) b_rd = merge_lanes(b_rd, a_dat_i, a_sel_i);
  end

  // Port A is written after port B so it wins any lane both ports enable.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < SW; n++) begin
      if (b_wr && b_sel_i[n]) mem[b_adr_i][8*n +: 8] <= b_dat_i[8*n +: 8];
      if (a_wr && a_sel_i[n]) mem[a_adr_i][8*n +: 8] <= a_dat_i[8*n +: 8];
    end
  end

  always_comb begin
    a_dat1_d = a_act ? a_rd : a_dat1_q;
    b_dat1_d = b_act ? b_rd : b_dat1_q;
    a_ack1_d = a_act;
    b_ack1_d = b_act;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_dat1_q <= '0;
      b_dat1_q <= '0;
      a_ack1_q <= 1'b0;
      b_ack1_q <= 1'b0;
    end else begin
      a_dat1_q <= a_dat1_d;
      b_dat1_q <= b_dat1_d;
      a_ack1_q <= a_ack1_d;
      b_ack1_q <= b_ack1_d;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [DW-1:0] a_dat2_q, a_dat2_d, b_dat2_q, b_dat2_d;
    logic          a_ack2_q, a_ack2_d, b_ack2_q, b_ack2_d;

    always_comb begin
      a_dat2_d = a_ack1_q ? a_dat1_q : a_dat2_q;
      b_dat2_d = b_ack1_q ? b_dat1_q : b_dat2_q;
      a_ack2_d = a_ack1_q;
      b_ack2_d = b_ack1_q;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_dat2_q <= '0;
        b_dat2_q <= '0;
        a_ack2_q <= 1'b0;
        b_ack2_q <= 1'b0;
      end else begin
        a_dat2_q <= a_dat2_d;
        b_dat2_q <= b_dat2_d;
        a_ack2_q <= a_ack2_d;
        b_ack2_q <= b_ack2_d;
      end
    end

    assign a_dat_o = a_dat2_q;
    assign b_dat_o = b_dat2_q;
    assign a_ack_o = a_ack2_q;
    assign b_ack_o = b_ack2_q;
  end else begin : g_noreg
    assign a_dat_o = a_dat1_q;
    assign b_dat_o = b_dat1_q;
    assign a_ack_o = a_ack1_q;
    assign b_ack_o = b_ack1_q;
  end

endmodule

// File: tb/tb_aemb2_dpsram.sv
// Two DUT instances share one stimulus stream:
//   dut0: RDW=0 OREG=0 XFWD=0 (defaults)
//   dut1: RDW=1 OREG=1 XFWD=1
// Channel numbering: ch = 2*dut + port (port 0 = A, 1 = B).
module tb_aemb2_dpsram;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a_adr, b_adr;
  logic [31:0] a_dat, b_dat;
  logic [3:0]  a_sel, b_sel;
  logic        a_wre, a_ena, b_wre, b_ena;

  logic [31:0] d0_a_dat, d0_b_dat, d1_a_dat, d1_b_dat;
  logic        d0_a_ack, d0_b_ack, d1_a_ack, d1_b_ack;

  aemb2_dpsram #(.AW(8), .DW(32), .RDW(0), .OREG(0), .XFWD(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .a_adr_i(a_adr), .a_dat_i(a_dat), .a_sel_i(a_sel), .a_wre_i(a_wre), .a_ena_i(a_ena),
    .a_dat_o(d0_a_dat), .a_ack_o(d0_a_ack),
    .b_adr_i(b_adr), .b_dat_i(b_dat), .b_sel_i(b_sel), .b_wre_i(b_wre), .b_ena_i(b_ena),
    .b_dat_o(d0_b_dat), .b_ack_o(d0_b_ack));

  aemb2_dpsram #(.AW(8), .DW(32), .RDW(1), .OREG(1), .XFWD(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .a_adr_i(a_adr), .a_dat_i(a_dat), .a_sel_i(a_sel), .a_wre_i(a_wre), .a_ena_i(a_ena),
    .a_dat_o(d1_a_dat), .a_ack_o(d1_a_ack),
    .b_adr_i(b_adr), .b_dat_i(b_dat), .b_sel_i(b_sel), .b_wre_i(b_wre), .b_ena_i(b_ena),
    .b_dat_o(d1_b_dat), .b_ack_o(d1_b_ack));

  function automatic int cfg_rdw(input int d);  return (d == 1) ? 1 : 0; endfunction
  function automatic int cfg_oreg(input int d); return (d == 1) ? 1 : 0; endfunction
  function automatic int cfg_xfwd(input int d); return (d == 1) ? 1 : 0; endfunction

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t        sb_q [4][$];
  logic [31:0] ref_mem [256];
  logic [31:0] held [4];
  int          ecnt = 0;
  int          rst_edge = -1;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = w;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  // Reference behaviour of one clock edge, evaluated from the spec rules on
  // the inputs that were sampled at that edge.
  task automatic model_edge();
    logic        aw, bw, same;
    logic [31:0] va, vb;
    if (rst) begin
      rst_edge = ecnt;
      for (int ch = 0; ch < 4; ch++)
        while (sb_q[ch].size() > 0 && sb_q[ch][sb_q[ch].size()-1].due >= ecnt)
          void'(sb_q[ch].pop_back());
    end else begin
      aw   = a_ena && a_wre;
      bw   = b_ena && b_wre;
      same = (a_adr == b_adr);
      for (int d = 0; d < 2; d++) begin
        if (a_ena) begin
          va = ref_mem[a_adr];
          if (cfg_xfwd(d) == 1 && bw && same) va = merge(va, b_dat, b_sel);
          if (cfg_rdw(d) == 0 && aw)          va = merge(va, a_dat, a_sel);
          sb_q[2*d].push_back('{dat: va, due: ecnt + cfg_oreg(d)});
        end
        if (b_ena) begin
          vb = ref_mem[b_adr];
          if (cfg_rdw(d) == 0 && bw)          vb = merge(vb, b_dat, b_sel);
          if (cfg_xfwd(d) == 1 && aw && same) vb = merge(vb, a_dat, a_sel);
          sb_q[2*d+1].push_back('{dat: vb, due: ecnt + cfg_oreg(d)});
        end
      end
      if (bw) ref_mem[b_adr] = merge(ref_mem[b_adr], b_dat, b_sel);
      if (aw) ref_mem[a_adr] = merge(ref_mem[a_adr], a_dat, a_sel);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ecnt++;
    model_edge();
    #1;
  endtask

  task automatic set_a(input logic ena, input logic wre, input logic [7:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    a_ena = ena; a_wre = wre; a_adr = adr; a_dat = dat; a_sel = sel;
  endtask

  task automatic set_b(input logic ena, input logic wre, input logic [7:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    b_ena = ena; b_wre = wre; b_adr = adr; b_dat = dat; b_sel = sel;
  endtask

  task automatic idle(input int n);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: pops expected responses whenever a DUT presents an ack.
  always @(negedge clk) begin
    logic [31:0] od [4];
    logic        oa [4];
    od[0] = d0_a_dat; od[1] = d0_b_dat; od[2] = d1_a_dat; od[3] = d1_b_dat;
    oa[0] = d0_a_ack; oa[1] = d0_b_ack; oa[2] = d1_a_ack; oa[3] = d1_b_ack;
    if (mon_en) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (rst_edge == ecnt) held[ch] = 32'h0;
        while (sb_q[ch].size() > 0 && sb_q[ch][0].due < ecnt) begin
          checks++; errors++;
          $display("FAIL missed_ack ch%0d edge %0d: no ack, required data %h due edge %0d",
                   ch, ecnt, sb_q[ch][0].dat, sb_q[ch][0].due);
          void'(sb_q[ch].pop_front());
        end
        checks++;
        if (oa[ch]) begin
          if (sb_q[ch].size() == 0 || sb_q[ch][0].due != ecnt) begin
            errors++;
            $display("FAIL unexpected_ack ch%0d edge %0d: ack=1 data %h, required ack=0",
                     ch, ecnt, od[ch]);
          end else begin
            if (od[ch] !== sb_q[ch][0].dat) begin
              errors++;
              $display("FAIL read_data ch%0d edge %0d: got %h, required %h",
                       ch, ecnt, od[ch], sb_q[ch][0].dat);
            end
            held[ch] = sb_q[ch][0].dat;
            void'(sb_q[ch].pop_front());
          end
        end else if (od[ch] !== held[ch]) begin
          errors++;
          $display("FAIL hold_data ch%0d edge %0d: got %h, required %h",
                   ch, ecnt, od[ch], held[ch]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_a(1, 1, 8'h05, 32'hCAFEF00D, 4'hF);  // ignored: presented during reset
    set_b(1, 1, 8'h06, 32'h12345678, 4'hF);
    step();
    idle(1);
    for (int ch = 0; ch < 4; ch++) held[ch] = 32'h0;
    mon_en = 1'b1;
    rst = 1'b0;

    // Fill the whole array so every later read has a known expected value.
    for (int i = 0; i < 128; i++) begin
      set_a(1, 1, 8'(2*i),   $urandom, 4'hF);
      set_b(1, 1, 8'(2*i+1), $urandom, 4'hF);
      step();
    end
    idle(2);

    // Basic write then read.
    set_a(1, 1, 8'h10, 32'hDEADBEEF, 4'hF); step();
    set_a(1, 0, 8'h10, 32'h0, 4'h0);        step();
    idle(3);

    // Byte lanes on port B.
    set_b(1, 1, 8'h20, 32'h11223344, 4'hF); step();
    set_b(1, 1, 8'h20, 32'hAABBCCDD, 4'h5); step();
    set_b(1, 0, 8'h20, 32'h0, 4'h0);        step();
    idle(3);

    // Read during write on the same port.
    set_a(1, 1, 8'h30, 32'h0, 4'hF);        step();
    set_a(1, 1, 8'h30, 32'h12345678, 4'hF); step();
    idle(3);

    // Cross-port collision: A writes low lanes while B reads.
    set_a(1, 1, 8'h40, 32'hFFFFFFFF, 4'hF); step();
    set_a(1, 1, 8'h40, 32'h0, 4'h3);
    set_b(1, 0, 8'h40, 32'h0, 4'h0);        step();
    set_a(1, 0, 8'h40, 32'h0, 4'h0);
    set_b(0, 0, 8'h00, 32'h0, 4'h0);        step();
    idle(3);

    // Write-write collision on the same address and a sel=0 write.
    set_a(1, 1, 8'h50, 32'h11111111, 4'hF);
    set_b(1, 1, 8'h50, 32'h22222222, 4'hC); step();
    set_a(1, 0, 8'h50, 32'h0, 4'h0);
    set_b(1, 1, 8'h50, 32'h33333333, 4'h0); step();
    set_b(1, 0, 8'h50, 32'h0, 4'h0);        step();
    idle(3);

    // Streamed reads with reset landing in the cycle after the third read.
    set_a(1, 0, 8'h00, 32'h0, 4'h0); step();
    set_a(1, 0, 8'h01, 32'h0, 4'h0); step();
    set_a(1, 0, 8'h02, 32'h0, 4'h0); step();
    set_a(1, 0, 8'h03, 32'h0, 4'h0);
    rst = 1'b1;                      step();
    rst = 1'b0;
    idle(4);

    // Randomised traffic over a narrow address window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_a($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
            $urandom, 4'($urandom));
      set_b($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
            $urandom, 4'($urandom));
      step();
    end
    rst = 1'b0;
    idle(5);

    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (sb_q[ch].size() != 0) begin
        errors++;
        $display("FAIL drain ch%0d: %0d responses outstanding, required 0",
                 ch, sb_q[ch].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
